// File: rtl/alu_issue_arbiter_if.sv
// Request, ALU and response signal bundle shared between the two requesters,
// the ALU and the issue arbiter. Per-requester fields keep their own names so
// each requester's wiring is explicit.
interface alu_issue_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [3:0]       req_op0;
    logic [3:0]       req_op1;
    logic [1:0]       req_sel0;
    logic [1:0]       req_sel1;
    logic [XLEN-1:0]  req_a0;
    logic [XLEN-1:0]  req_a1;
    logic [XLEN-1:0]  req_b0;
    logic [XLEN-1:0]  req_b1;
    logic [TAG_W-1:0] req_tag0;
    logic [TAG_W-1:0] req_tag1;

    logic [3:0]       alu_op;
    logic [XLEN-1:0]  alu_in1;
    logic [XLEN-1:0]  alu_in2;
    logic [XLEN-1:0]  alu_out;
    logic [XLEN-1:0]  alu_slt;
    logic [XLEN-1:0]  alu_sltu;

    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [XLEN-1:0]  rsp_data0;
    logic [XLEN-1:0]  rsp_data1;
    logic [TAG_W-1:0] rsp_tag0;
    logic [TAG_W-1:0] rsp_tag1;
    logic [1:0]       rsp_err;
    logic             busy;

    // Requester/ALU/consumer side
    modport master (
        output req_valid, req_op0, req_op1, req_sel0, req_sel1,
               req_a0, req_a1, req_b0, req_b1, req_tag0, req_tag1,
        input  req_ready,
        input  alu_op, alu_in1, alu_in2,
        output alu_out, alu_slt, alu_sltu,
        input  rsp_valid, rsp_data0, rsp_data1, rsp_tag0, rsp_tag1, rsp_err, busy,
        output rsp_ready
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_op0, req_op1, req_sel0, req_sel1,
               req_a0, req_a1, req_b0, req_b1, req_tag0, req_tag1,
        output req_ready,
        output alu_op, alu_in1, alu_in2,
        input  alu_out, alu_slt, alu_sltu,
        output rsp_valid, rsp_data0, rsp_data1, rsp_tag0, rsp_tag1, rsp_err, busy,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Shares one registered ALU between two requesters. Round-robin grant, one op
// per cycle, result captured the cycle after issue and returned through a
// per-requester first-word-fall-through FIFO. A requester is only granted when
// its FIFO is guaranteed to have room for the result, so nothing is dropped.
module alu_issue_arbiter #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 2
) (
    input logic                clk,
    input logic                rst_n,
    alu_issue_arbiter_if.slave bus
);
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int CNT_W1 = CNT_W + 1;
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CNT_W:0]   DEPTH_C  = CNT_W1'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

    logic [3:0]       op_w  [2];
    logic [1:0]       sel_w [2];
    logic [XLEN-1:0]  a_w   [2];
    logic [XLEN-1:0]  b_w   [2];
    logic [TAG_W-1:0] tag_w [2];
    logic [1:0]       ill_w;

    logic             prio_q, prio_d;
    logic             infl_q;
    logic             infl_id_q;
    logic [TAG_W-1:0] infl_tag_q;
    logic [1:0]       infl_sel_q;
    logic             infl_err_q;

    logic [CNT_W-1:0] cnt_q    [2];
    logic [CNT_W-1:0] cnt_d    [2];
    logic [PTR_W-1:0] wr_ptr_q [2];
    logic [PTR_W-1:0] rd_ptr_q [2];
    logic [XLEN-1:0]  mem_data_q [2][RSP_DEPTH];
    logic [TAG_W-1:0] mem_tag_q  [2][RSP_DEPTH];
    logic             mem_err_q  [2][RSP_DEPTH];

    logic [1:0]       elig, cand, gnt, push, pop, rsp_valid_w;
    logic             win_id;
    logic [XLEN-1:0]  cap_data;

    assign op_w[0]  = bus.req_op0;
    assign op_w[1]  = bus.req_op1;
    assign sel_w[0] = bus.req_sel0;
    assign sel_w[1] = bus.req_sel1;
    assign a_w[0]   = bus.req_a0;
    assign a_w[1]   = bus.req_a1;
    assign b_w[0]   = bus.req_b0;
    assign b_w[1]   = bus.req_b1;
    assign tag_w[0] = bus.req_tag0;
    assign tag_w[1] = bus.req_tag1;
    assign ill_w[0] = op_w[0][3] | (sel_w[0] == 2'b11);
    assign ill_w[1] = op_w[1][3] | (sel_w[1] == 2'b11);

    // Eligibility from registered occupancy, then round-robin grant
    always_comb begin
        elig = '0;
        for (int i = 0; i < 2; i++) begin
            elig[i] = ({1'b0, cnt_q[i]} +
                       {{CNT_W{1'b0}}, infl_q && (infl_id_q == 1'(i))}) < DEPTH_C;
        end
        cand = bus.req_valid & elig;
        gnt  = cand;
        if (cand == 2'b11) begin
            gnt = prio_q ? 2'b10 : 2'b01;
        end
        win_id = gnt[1];
        prio_d = prio_q;
        if (|gnt) begin
            prio_d = ~win_id;
        end
    end

    assign bus.req_ready = gnt;

    // Drive the ALU from the winner; illegal requests present idle values
    always_comb begin
        bus.alu_op  = '0;
        bus.alu_in1 = '0;
        bus.alu_in2 = '0;
        if (|gnt && !ill_w[win_id]) begin
            bus.alu_op  = op_w[win_id];
            bus.alu_in1 = a_w[win_id];
            bus.alu_in2 = b_w[win_id];
        end
    end

    // In-flight slot and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q     <= 1'b0;
            infl_q     <= 1'b0;
            infl_id_q  <= 1'b0;
            infl_tag_q <= '0;
            infl_sel_q <= '0;
            infl_err_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
            infl_q <= |gnt;
            if (|gnt) begin
                infl_id_q  <= win_id;
                infl_tag_q <= tag_w[win_id];
                infl_sel_q <= sel_w[win_id];
                infl_err_q <= ill_w[win_id];
            end
        end
    end

    // Result selection in the capture cycle and FIFO occupancy next-state
    always_comb begin
        cap_data = '0;
        if (!infl_err_q) begin
            case (infl_sel_q)
                2'b00:   cap_data = bus.alu_out;
                2'b01:   cap_data = bus.alu_slt;
                2'b10:   cap_data = bus.alu_sltu;
                default: cap_data = '0;
            endcase
        end
        push = '0;
        if (infl_q) begin
            push[infl_id_q] = 1'b1;
        end
        pop = rsp_valid_w & bus.rsp_ready;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!push[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // FIFO pointers and counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]    <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (push[i]) begin
                    wr_ptr_q[i] <= (wr_ptr_q[i] == LAST_PTR) ? '0 : wr_ptr_q[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= (rd_ptr_q[i] == LAST_PTR) ? '0 : rd_ptr_q[i] + 1'b1;
                end
            end
        end
    end

    // FIFO storage; contents are meaningless while the count is zero
    always_ff @(posedge clk) begin
        if (infl_q) begin
            mem_data_q[infl_id_q][wr_ptr_q[infl_id_q]] <= cap_data;
            mem_tag_q[infl_id_q][wr_ptr_q[infl_id_q]]  <= infl_tag_q;
            mem_err_q[infl_id_q][wr_ptr_q[infl_id_q]]  <= infl_err_q;
        end
    end

    assign rsp_valid_w[0] = (cnt_q[0] != '0);
    assign rsp_valid_w[1] = (cnt_q[1] != '0);
    assign bus.rsp_valid  = rsp_valid_w;
    assign bus.rsp_data0  = mem_data_q[0][rd_ptr_q[0]];
    assign bus.rsp_data1  = mem_data_q[1][rd_ptr_q[1]];
    assign bus.rsp_tag0   = mem_tag_q[0][rd_ptr_q[0]];
    assign bus.rsp_tag1   = mem_tag_q[1][rd_ptr_q[1]];
    assign bus.rsp_err[0] = mem_err_q[0][rd_ptr_q[0]];
    assign bus.rsp_err[1] = mem_err_q[1][rd_ptr_q[1]];
    assign bus.busy       = infl_q | (|rsp_valid_w);
endmodule

// File: tb/tb_alu_issue_arbiter.sv
module tb_alu_issue_arbiter;
    localparam int XLEN      = 32;
    localparam int TAG_W     = 4;
    localparam int RSP_DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    alu_issue_arbiter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();

    alu_issue_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        case (op[2:0])
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return $signed(a) >>> b[4:0];
        endcase
    endfunction

    // Registered ALU model seen by the arbiter
    always @(posedge clk) begin
        bus.alu_out  <= alu_f(bus.alu_op, bus.alu_in1, bus.alu_in2);
        bus.alu_slt  <= XLEN'($signed(bus.alu_in1) < $signed(bus.alu_in2));
        bus.alu_sltu <= XLEN'(bus.alu_in1 < bus.alu_in2);
    end

    // Expected response data straight from the request fields
    function automatic logic [XLEN-1:0] exp_data(input logic [3:0] op, input logic [1:0] sel,
                                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        if (op >= 4'h8 || sel == 2'b11) return '0;
        case (sel)
            2'b00:   return alu_f(op, a, b);
            2'b01:   return XLEN'($signed(a) < $signed(b));
            default: return XLEN'(a < b);
        endcase
    endfunction

    task automatic idle_reqs();
        bus.req_valid = 2'b00;
        bus.req_op0 = '0; bus.req_op1 = '0;
        bus.req_sel0 = '0; bus.req_sel1 = '0;
        bus.req_a0 = '0; bus.req_a1 = '0;
        bus.req_b0 = '0; bus.req_b1 = '0;
        bus.req_tag0 = '0; bus.req_tag1 = '0;
    endtask

    task automatic drive_req(input int i, input logic [3:0] op, input logic [1:0] sel,
                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [TAG_W-1:0] tag);
        if (i == 0) begin
            bus.req_op0 = op; bus.req_sel0 = sel; bus.req_a0 = a; bus.req_b0 = b;
            bus.req_tag0 = tag; bus.req_valid[0] = 1'b1;
        end else begin
            bus.req_op1 = op; bus.req_sel1 = sel; bus.req_a1 = a; bus.req_b1 = b;
            bus.req_tag1 = tag; bus.req_valid[1] = 1'b1;
        end
    endtask

    task automatic do_reset();
        idle_reqs();
        bus.rsp_ready = 2'b11;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_reqs();
        bus.rsp_ready = 2'b11;
        rst_n = 1'b0;
        #2;
        total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got %b want 00", bus.rsp_valid); end
        total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got %b want 00", bus.req_ready); end
        total++; if (bus.alu_op !== 4'h0) begin bad++; $display("FAIL reset_alu_op got %h want 0", bus.alu_op); end
        total++; if (bus.alu_in1 !== '0 || bus.alu_in2 !== '0) begin bad++; $display("FAIL reset_alu_in got %h/%h want 0/0", bus.alu_in1, bus.alu_in2); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_add();
        drive_req(0, 4'h0, 2'b00, 32'd5, 32'd7, 4'd3);
        @(negedge clk);
        total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL add_req_ready got %b want 01", bus.req_ready); end
        total++; if (bus.alu_op !== 4'h0 || bus.alu_in1 !== 32'd5 || bus.alu_in2 !== 32'd7) begin
            bad++; $display("FAIL add_alu_drive got %h/%h/%h want 0/5/7", bus.alu_op, bus.alu_in1, bus.alu_in2); end
        @(posedge clk); #1;
        idle_reqs();
        @(negedge clk);
        total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL add_early_rsp got %b want 00", bus.rsp_valid); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL add_busy got %b want 1", bus.busy); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.rsp_valid !== 2'b01 || bus.rsp_data0 !== 32'd12 || bus.rsp_tag0 !== 4'd3 || bus.rsp_err[0] !== 1'b0) begin
            bad++; $display("FAIL add_rsp got v=%b d=%h t=%h e=%b want v=01 d=c t=3 e=0", bus.rsp_valid, bus.rsp_data0, bus.rsp_tag0, bus.rsp_err[0]); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL add_drain got v=%b busy=%b want 00/0", bus.rsp_valid, bus.busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_slt_sltu();
        logic [1:0]       sels [3] = '{2'b01, 2'b10, 2'b00};
        logic [TAG_W-1:0] tags [3] = '{4'd1, 4'd2, 4'd3};
        logic [XLEN-1:0]  expd [3] = '{32'd1, 32'd0, 32'hFFFF_FFFE};
        int k = 0;
        int nr = 0;
        do_reset();
        drive_req(1, 4'h1, sels[0], 32'hFFFF_FFFF, 32'd1, tags[0]);
        for (int c = 0; c < 30 && nr < 3; c++) begin
            @(negedge clk);
            if (bus.rsp_valid[1]) begin
                total++;
                if (bus.rsp_data1 !== expd[nr] || bus.rsp_tag1 !== tags[nr] || bus.rsp_err[1] !== 1'b0) begin
                    bad++; $display("FAIL slt_rsp%0d got d=%h t=%h e=%b want d=%h t=%h e=0", nr, bus.rsp_data1, bus.rsp_tag1, bus.rsp_err[1], expd[nr], tags[nr]); end
                nr++;
            end
            if (bus.req_valid[1] && bus.req_ready[1]) k++;
            @(posedge clk); #1;
            if (k < 3) drive_req(1, 4'h1, sels[k], 32'hFFFF_FFFF, 32'd1, tags[k]);
            else bus.req_valid[1] = 1'b0;
        end
        idle_reqs();
        total++; if (nr != 3 || k != 3) begin bad++; $display("FAIL slt_count got acc=%0d rsp=%0d want 3/3", k, nr); end
    endtask

    task automatic test_contention();
        int acc [2] = '{0, 0};
        int nr  [2] = '{0, 0};
        logic [XLEN-1:0] ed;
        do_reset();
        for (int i = 0; i < 2; i++) drive_req(i, 4'h0, 2'b00, XLEN'(i * 100), 32'd1, TAG_W'(i * 4));
        for (int c = 0; c < 30 && (nr[0] < 3 || nr[1] < 3); c++) begin
            @(negedge clk);
            if (c < 6) begin
                total++;
                if (bus.req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                    bad++; $display("FAIL contention_grant c=%0d got %b want %b", c, bus.req_ready, (c % 2 == 0) ? 2'b01 : 2'b10); end
            end
            if (bus.rsp_valid[0]) begin
                ed = XLEN'(nr[0] + nr[0] + 1);
                total++;
                if (bus.rsp_data0 !== ed || bus.rsp_tag0 !== TAG_W'(nr[0])) begin
                    bad++; $display("FAIL contention_rsp0 got d=%h t=%h want d=%h t=%h", bus.rsp_data0, bus.rsp_tag0, ed, TAG_W'(nr[0])); end
                nr[0]++;
            end
            if (bus.rsp_valid[1]) begin
                ed = XLEN'(100 + nr[1] + nr[1] + 1);
                total++;
                if (bus.rsp_data1 !== ed || bus.rsp_tag1 !== TAG_W'(4 + nr[1])) begin
                    bad++; $display("FAIL contention_rsp1 got d=%h t=%h want d=%h t=%h", bus.rsp_data1, bus.rsp_tag1, ed, TAG_W'(4 + nr[1])); end
                nr[1]++;
            end
            for (int i = 0; i < 2; i++) if (bus.req_valid[i] && bus.req_ready[i]) acc[i]++;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i] < 3) drive_req(i, 4'h0, 2'b00, XLEN'(i * 100 + acc[i]), XLEN'(acc[i] + 1), TAG_W'(i * 4 + acc[i]));
                else bus.req_valid[i] = 1'b0;
            end
        end
        idle_reqs();
        total++; if (nr[0] != 3 || nr[1] != 3) begin bad++; $display("FAIL contention_count got %0d/%0d want 3/3", nr[0], nr[1]); end
    endtask

    task automatic test_backpressure();
        int acc0 = 0;
        int acc1 = 0;
        int got = 0;
        do_reset();
        bus.rsp_ready = 2'b10;
        for (int c = 0; c < 8; c++) begin
            drive_req(0, 4'h0, 2'b00, XLEN'(acc0), 32'd10, TAG_W'(acc0));
            drive_req(1, 4'h2, 2'b00, 32'h0000_F0F0, 32'h0000_FF00, TAG_W'(c));
            @(negedge clk);
            if (bus.req_ready[0]) acc0++;
            if (bus.req_ready[1]) acc1++;
            @(posedge clk); #1;
        end
        total++; if (acc0 != 2) begin bad++; $display("FAIL bp_accept0 got %0d want 2", acc0); end
        total++; if (acc1 < 3) begin bad++; $display("FAIL bp_accept1 got %0d want >=3", acc1); end
        bus.req_valid[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (bus.req_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_hold got %b want 0", bus.req_ready[0]); end
            @(posedge clk); #1;
        end
        bus.rsp_ready[0] = 1'b1;
        @(negedge clk);
        total++; if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_tag0 !== 4'd0 || bus.rsp_data0 !== 32'd10) begin
            bad++; $display("FAIL bp_first_pop got v=%b t=%h d=%h want 1/0/a", bus.rsp_valid[0], bus.rsp_tag0, bus.rsp_data0); end
        total++; if (bus.req_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_pop_cycle_ready got %b want 0", bus.req_ready[0]); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.req_ready[0] !== 1'b1) begin bad++; $display("FAIL bp_resume got %b want 1", bus.req_ready[0]); end
        total++; if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_tag0 !== 4'd1 || bus.rsp_data0 !== 32'd11) begin
            bad++; $display("FAIL bp_second_pop got v=%b t=%h d=%h want 1/1/b", bus.rsp_valid[0], bus.rsp_tag0, bus.rsp_data0); end
        @(posedge clk); #1;
        idle_reqs();
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk);
            if (bus.rsp_valid[0]) begin
                got = 1;
                total++; if (bus.rsp_tag0 !== 4'd2 || bus.rsp_data0 !== 32'd12) begin
                    bad++; $display("FAIL bp_third got t=%h d=%h want 2/c", bus.rsp_tag0, bus.rsp_data0); end
            end
            @(posedge clk); #1;
        end
        total++; if (got == 0) begin bad++; $display("FAIL bp_third_timeout got none want one response"); end
    endtask

    task automatic test_illegal();
        logic [3:0] ops  [2] = '{4'h9, 4'h2};
        logic [1:0] sels [2] = '{2'b00, 2'b11};
        logic [TAG_W-1:0] tags [2] = '{4'd7, 4'd5};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive_req(0, ops[k], sels[k], $urandom() | 32'h1, $urandom() | 32'h1, tags[k]);
            @(negedge clk);
            total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL illegal%0d_ready got %b want 01", k, bus.req_ready); end
            total++; if (bus.alu_op !== 4'h0 || bus.alu_in1 !== '0 || bus.alu_in2 !== '0) begin
                bad++; $display("FAIL illegal%0d_alu got %h/%h/%h want 0/0/0", k, bus.alu_op, bus.alu_in1, bus.alu_in2); end
            @(posedge clk); #1;
            idle_reqs();
            @(posedge clk); #1;
            @(negedge clk);
            total++; if (bus.rsp_valid !== 2'b01 || bus.rsp_data0 !== '0 || bus.rsp_tag0 !== tags[k] || bus.rsp_err[0] !== 1'b1) begin
                bad++; $display("FAIL illegal%0d_rsp got v=%b d=%h t=%h e=%b want 01/0/%h/1", k, bus.rsp_valid, bus.rsp_data0, bus.rsp_tag0, bus.rsp_err[0], tags[k]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        drive_req(0, 4'h0, 2'b00, 32'd5, 32'd7, 4'd3);
        @(posedge clk); #1;
        idle_reqs();
        rst_n = 1'b0;
        #1;
        total++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL midrst_in_reset got v=%b busy=%b want 00/0", bus.rsp_valid, bus.busy); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin
                bad++; $display("FAIL midrst_after got v=%b busy=%b want 00/0", bus.rsp_valid, bus.busy); end
            @(posedge clk); #1;
        end
        test_single_add();
    endtask

    typedef struct {
        logic [XLEN-1:0]  d;
        logic [TAG_W-1:0] t;
        logic             e;
        int               c;
    } rsp_t;

    task automatic randomize_inputs();
        for (int i = 0; i < 2; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            drive_req(i, op, 2'($urandom_range(0, 3)), $urandom(), $urandom(), TAG_W'($urandom_range(0, 15)));
        end
        bus.req_valid = 2'($urandom_range(0, 3));
        bus.rsp_ready[0] = ($urandom_range(0, 3) != 0);
        bus.rsp_ready[1] = ($urandom_range(0, 3) != 0);
    endtask

    task automatic test_random();
        rsp_t mq [2][$];
        rsp_t r;
        logic prio = 1'b0;
        logic [1:0] eg, ev;
        logic w;
        do_reset();
        randomize_inputs();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            eg[0] = bus.req_valid[0] && (mq[0].size() < RSP_DEPTH);
            eg[1] = bus.req_valid[1] && (mq[1].size() < RSP_DEPTH);
            if (eg == 2'b11) eg = prio ? 2'b10 : 2'b01;
            total++; if (bus.req_ready !== eg) begin bad++; $display("FAIL rnd_grant cyc=%0d got %b want %b", cyc, bus.req_ready, eg); end
            for (int i = 0; i < 2; i++) ev[i] = (mq[i].size() > 0) && (mq[i][0].c + 2 <= cyc);
            total++; if (bus.rsp_valid !== ev) begin bad++; $display("FAIL rnd_rsp_valid cyc=%0d got %b want %b", cyc, bus.rsp_valid, ev); end
            if (bus.rsp_valid[0] && bus.rsp_ready[0] && mq[0].size() > 0) begin
                r = mq[0].pop_front();
                total++; if (bus.rsp_data0 !== r.d || bus.rsp_tag0 !== r.t || bus.rsp_err[0] !== r.e) begin
                    bad++; $display("FAIL rnd_rsp0 cyc=%0d got d=%h t=%h e=%b want d=%h t=%h e=%b", cyc, bus.rsp_data0, bus.rsp_tag0, bus.rsp_err[0], r.d, r.t, r.e); end
            end
            if (bus.rsp_valid[1] && bus.rsp_ready[1] && mq[1].size() > 0) begin
                r = mq[1].pop_front();
                total++; if (bus.rsp_data1 !== r.d || bus.rsp_tag1 !== r.t || bus.rsp_err[1] !== r.e) begin
                    bad++; $display("FAIL rnd_rsp1 cyc=%0d got d=%h t=%h e=%b want d=%h t=%h e=%b", cyc, bus.rsp_data1, bus.rsp_tag1, bus.rsp_err[1], r.d, r.t, r.e); end
            end
            if (eg != 2'b00) begin
                w = eg[1];
                if (w == 1'b0) begin
                    r.d = exp_data(bus.req_op0, bus.req_sel0, bus.req_a0, bus.req_b0);
                    r.t = bus.req_tag0;
                    r.e = (bus.req_op0 >= 4'h8) || (bus.req_sel0 == 2'b11);
                end else begin
                    r.d = exp_data(bus.req_op1, bus.req_sel1, bus.req_a1, bus.req_b1);
                    r.t = bus.req_tag1;
                    r.e = (bus.req_op1 >= 4'h8) || (bus.req_sel1 == 2'b11);
                end
                r.c = cyc;
                mq[w].push_back(r);
                prio = ~w;
            end
            @(posedge clk); #1;
            randomize_inputs();
        end
        idle_reqs();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_slt_sltu();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
